// File: rtl/serial_add_pkg.sv
// Shared definitions for the serial 3-bit-slice adder controller.
package serial_add_pkg;

    localparam int unsigned SLICE_W = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic int unsigned nslice_of(input int unsigned width);
        return width / SLICE_W;
    endfunction

endpackage

// File: rtl/add3_slice.sv
// 3-bit combinational ripple-carry adder slice.
module add3_slice (
    input  logic [2:0] a,
    input  logic [2:0] b,
    input  logic       ci,
    output logic [2:0] s,
    output logic       co
);

    logic c;

    always_comb begin
        s = '0;
        c = ci;
        for (int unsigned i = 0; i < 3; i++) begin
            s[i] = a[i] ^ b[i] ^ c;
            c    = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        co = c;
    end

endmodule

// File: rtl/serial_add3_ctrl.sv
// Sequences one add3_slice over WIDTH-bit operands, LSB slice first, one slice per clock.
module serial_add3_ctrl
    import serial_add_pkg::*;
#(
    parameter int unsigned WIDTH = 12
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    localparam int unsigned NSLICE = nslice_of(WIDTH);
    localparam int unsigned IDX_W  = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NSLICE - 1);

    if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_bad_width
        $error("serial_add3_ctrl: WIDTH must be a nonzero multiple of 3");
    end

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] res_next;
    logic             carry;
    logic [IDX_W-1:0] idx;
    logic [2:0]       slice_s;
    logic             slice_co;
    logic             last;

    assign last = (idx == LAST_IDX);

    add3_slice u_slice (
        .a  (op_a[2:0]),
        .b  (op_b[2:0]),
        .ci (carry),
        .s  (slice_s),
        .co (slice_co)
    );

    // Slice sums enter at the top so that after NSLICE steps the LSB slice sits at bit 0.
    if (WIDTH == SLICE_W) begin : g_res_single
        assign res_next = slice_s;
    end else begin : g_res_shift
        assign res_next = {slice_s, res[WIDTH-1:SLICE_W]};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = RUN;
            RUN:     if (last) state_next = DONE;
            DONE:    state_next = start ? RUN : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        case (state)
            RUN:     busy = 1'b1;
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            idx   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        op_a  <= a;
                        op_b  <= b;
                        carry <= cin;
                        idx   <= '0;
                    end
                end
                RUN: begin
                    op_a  <= op_a >> SLICE_W;
                    op_b  <= op_b >> SLICE_W;
                    carry <= slice_co;
                    res   <= res_next;
                    if (last) begin
                        sum  <= res_next;
                        cout <= slice_co;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_serial_add3_ctrl.sv
// Directed self-checking bench for serial_add3_ctrl at WIDTH=12 and WIDTH=3.
module tb_serial_add3_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [11:0] a = '0;
    logic [11:0] b = '0;
    logic        cin = 1'b0;
    logic        busy;
    logic        done;
    logic [11:0] sum;
    logic        cout;

    logic        start3 = 1'b0;
    logic [2:0]  a3 = '0;
    logic [2:0]  b3 = '0;
    logic        cin3 = 1'b0;
    logic        busy3;
    logic        done3;
    logic [2:0]  sum3;
    logic        cout3;

    int checks = 0;
    int failures = 0;

    serial_add3_ctrl #(.WIDTH(12)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add3_ctrl #(.WIDTH(3)) dut3 (
        .clk   (clk),
        .rst   (rst),
        .start (start3),
        .a     (a3),
        .b     (b3),
        .cin   (cin3),
        .busy  (busy3),
        .done  (done3),
        .sum   (sum3),
        .cout  (cout3)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One WIDTH=12 add; poke re-pulses start with other operands in the 2nd RUN cycle.
    task automatic run12(input logic [11:0] ta, input logic [11:0] tb_v, input logic tc,
                         input logic [11:0] es, input logic ec, input bit poke, input string tag);
        int n;
        int busy_n;
        bit got;
        bit stable;
        logic [11:0] held;
        @(negedge clk);
        a = ta; b = tb_v; cin = tc; start = 1'b1;
        held = sum;
        @(posedge clk); #1;
        start = 1'b0;
        busy_n = busy ? 1 : 0;
        stable = (sum === held);
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            n++;
            start = 1'b0;
            if (done) begin
                got = 1'b1;
            end else begin
                if (busy) busy_n++;
                if (sum !== held) stable = 1'b0;
                if (poke && n == 1) begin
                    start = 1'b1; a = 12'hABC; b = 12'h123; cin = 1'b1;
                end
            end
        end
        check({tag, "_latency"}, n, 4);
        check({tag, "_busy_cycles"}, busy_n, 4);
        check({tag, "_sum_stable"}, {31'd0, stable}, 1);
        check({tag, "_sum"}, {20'd0, sum}, {20'd0, es});
        check({tag, "_cout"}, {31'd0, cout}, {31'd0, ec});
        @(posedge clk); #1;
        check({tag, "_done_single"}, {31'd0, done}, 0);
        check({tag, "_idle"}, {31'd0, busy}, 0);
    endtask

    task automatic run3(input logic [2:0] ta, input logic [2:0] tb_v, input logic tc,
                        input logic [2:0] es, input logic ec, input string tag);
        int n;
        bit got;
        @(negedge clk);
        a3 = ta; b3 = tb_v; cin3 = tc; start3 = 1'b1;
        @(posedge clk); #1;
        start3 = 1'b0;
        got = 1'b0;
        n = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(posedge clk); #1;
            n++;
            if (done3) got = 1'b1;
        end
        check({tag, "_latency"}, n, 1);
        check({tag, "_sum"}, {29'd0, sum3}, {29'd0, es});
        check({tag, "_cout"}, {31'd0, cout3}, {31'd0, ec});
    endtask

    initial begin
        int d1;
        int d2;
        int n;
        int done_n;
        logic gap_busy;
        logic [11:0] ra;
        logic [11:0] rb;
        logic        rc;
        logic [12:0] t;

        #2 rst = 1'b1;
        #1;
        check("reset_busy", {31'd0, busy}, 0);
        check("reset_done", {31'd0, done}, 0);
        check("reset_sum", {20'd0, sum}, 0);
        check("reset_cout", {31'd0, cout}, 0);
        check("reset_sum3", {29'd0, sum3}, 0);
        @(negedge clk);
        rst = 1'b0;

        run12(12'h123, 12'h456, 1'b1, 12'h57A, 1'b0, 1'b0, "add_basic");
        run12(12'hFFF, 12'h001, 1'b0, 12'h000, 1'b1, 1'b0, "ripple_all");
        run12(12'hABC, 12'hDEF, 1'b1, 12'h8AC, 1'b1, 1'b0, "mixed");
        run12(12'hFFF, 12'hFFF, 1'b1, 12'hFFF, 1'b1, 1'b0, "max");
        run12(12'h000, 12'h000, 1'b0, 12'h000, 1'b0, 1'b0, "zero");
        run12(12'h111, 12'h222, 1'b0, 12'h333, 1'b0, 1'b1, "ignore_run_start");

        // Back-to-back: start held high, second operands presented while the first runs.
        @(negedge clk);
        a = 12'h007; b = 12'h001; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        a = 12'h800; b = 12'h800;
        d1 = -1; d2 = -1; n = 0; gap_busy = 1'b0;
        for (int i = 0; i < 20 && d2 < 0; i++) begin
            @(posedge clk); #1;
            n++;
            if (d1 > 0 && n == d1 + 1) gap_busy = busy;
            if (done) begin
                if (d1 < 0) begin
                    d1 = n;
                    check("b2b_sum1", {20'd0, sum}, 32'h008);
                    check("b2b_cout1", {31'd0, cout}, 0);
                end else begin
                    d2 = n;
                    start = 1'b0;
                    check("b2b_sum2", {20'd0, sum}, 32'h000);
                    check("b2b_cout2", {31'd0, cout}, 1);
                end
            end
        end
        start = 1'b0;
        check("b2b_first_done", d1, 4);
        check("b2b_spacing", d2 - d1, 5);
        check("b2b_no_idle_gap", {31'd0, gap_busy}, 1);
        @(posedge clk); #1;
        check("b2b_idle_after", {31'd0, busy | done}, 0);

        // Async reset in the second RUN cycle, with a nonzero prior sum.
        run12(12'h321, 12'h123, 1'b0, 12'h444, 1'b0, 1'b0, "pre_reset");
        @(negedge clk);
        a = 12'h0F0; b = 12'h00F; cin = 1'b0; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        #1;
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_sum", {20'd0, sum}, 0);
        check("rst_cout", {31'd0, cout}, 0);
        @(negedge clk);
        rst = 1'b0;
        done_n = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (done || busy) done_n++;
        end
        check("rst_no_done", done_n, 0);
        run12(12'h0F0, 12'h00F, 1'b0, 12'h0FF, 1'b0, 1'b0, "post_reset");

        run3(3'd5, 3'd6, 1'b1, 3'd4, 1'b1, "w3_a");
        run3(3'd3, 3'd2, 1'b0, 3'd5, 1'b0, "w3_b");
        run3(3'd7, 3'd7, 1'b1, 3'd7, 1'b1, "w3_c");
        run3(3'd0, 3'd0, 1'b1, 3'd1, 1'b0, "w3_d");

        for (int i = 0; i < 20; i++) begin
            ra = 12'($urandom);
            rb = 12'($urandom);
            rc = 1'($urandom);
            t  = {1'b0, ra} + {1'b0, rb} + {12'd0, rc};
            run12(ra, rb, rc, t[11:0], t[12], 1'b0, "rand");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
